// File: rtl/router_wr_ctrl_if.sv
// Byte-stream and FIFO write-port bundle for the router write controller.
// The master side supplies packet bytes and the FIFO full flags; the slave
// side (the controller) returns backpressure, write strobes and status pulses.
interface router_wr_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [2:0]        fifo_full;
    logic              busy;
    logic [2:0]        fifo_wr_en;
    logic [DATA_W-1:0] fifo_data;
    logic              err;
    logic              pkt_done;

    modport master (
        output pkt_valid, data_in, fifo_full,
        input  busy, fifo_wr_en, fifo_data, err, pkt_done
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        output busy, fifo_wr_en, fifo_data, err, pkt_done
    );
endinterface

// File: rtl/router_wr_ctrl.sv
// Write-side packet controller of the 1x3 router. Decodes the header byte,
// steers header/payload/parity into one of three FIFO write ports, stalls
// while the selected FIFO is full and checks packet parity.
module router_wr_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input logic              wr_clk,
    input logic              reset,
    router_wr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PARITY,
        DROP
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] parity_acc;
    logic [1:0]        dest;
    logic              err_q;
    logic              done_q;

    logic [1:0]        hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic [3:0]        full_ext;
    logic [1:0]        wr_sel;
    logic              writing;
    logic              busy_c;
    logic              accept;

    // Header fields are decoded straight off the incoming byte; destination 3
    // has no FIFO, so its full flag is tied low.
    assign hdr_dest = bus.data_in[1:0];
    assign hdr_len  = bus.data_in[2 +: LEN_W];
    assign full_ext = {1'b0, bus.fifo_full};

    // Backpressure and write steering, combinational so a write lands on the
    // same edge that accepts the byte.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_sel  = dest;
        writing = 1'b0;
        busy_c  = 1'b0;
        case (state)
            IDLE: begin
                wr_sel  = hdr_dest;
                writing = (hdr_dest != 2'd3);
                busy_c  = bus.pkt_valid && writing && full_ext[hdr_dest];
            end
            LOAD, PARITY: begin
                writing = 1'b1;
                busy_c  = full_ext[dest];
            end
            default: begin
                writing = 1'b0;
                busy_c  = 1'b0;
            end
        endcase
        if (!reset) begin
            busy_c = 1'b1;
        end
        accept = bus.pkt_valid && !busy_c && reset;
    end

    assign bus.busy       = busy_c;
    assign bus.fifo_wr_en = (accept && writing) ? (3'b001 << wr_sel) : 3'b000;
    assign bus.fifo_data  = bus.data_in;
    assign bus.err        = err_q;
    assign bus.pkt_done   = done_q;

    // Packet sequencing: length count, parity accumulation and status pulses.
    always_ff @(posedge wr_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            parity_acc <= '0;
            dest       <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        count <= hdr_len;
                        if (hdr_dest == 2'd3) begin
                            err_q <= 1'b1;
                            state <= DROP;
                        end else begin
                            dest       <= hdr_dest;
                            parity_acc <= bus.data_in;
                            state      <= (hdr_len == '0) ? PARITY : LOAD;
                        end
                    end
                    LOAD: begin
                        parity_acc <= parity_acc ^ bus.data_in;
                        count      <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        done_q <= 1'b1;
                        err_q  <= (bus.data_in != parity_acc);
                        state  <= IDLE;
                    end
                    default: begin
                        // Dropping: len payload bytes plus the parity byte.
                        if (count == '0) begin
                            state <= IDLE;
                        end else begin
                            count <= count - LEN_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/router_wr_ctrl.md
# router_wr_ctrl

Write-side packet controller for the 1X3 router, in the `wr_clk` domain. It accepts a byte-serial packet stream and decodes the destination from the header byte. It steers header, payload and parity bytes into one of the three `asy_fifo` write ports, and applies backpressure while the selected FIFO is full. It checks packet parity and reports errors and packet completion.

## Interface
- DATA_W, 8, byte width of `data_in` and `fifo_data`; the header format below requires 8.
- LEN_W, 6, payload length field width, taken from header bits [7:2].

Ports:
- wr_clk  in  1  write clock shared with all three FIFO write ports.
- reset  in  1  synchronous, active-low.
- pkt_valid  in  1  source has a byte on `data_in` this cycle.
- data_in  in  DATA_W  packet byte.
- fifo_full  in  3  `wr_full` of FIFO 0..2, already in the `wr_clk` domain.
- busy  out  1  backpressure; a byte is accepted only on an edge with `pkt_valid=1 && busy=0`.
- fifo_wr_en  out  3  one-hot write enable to FIFO 0..2.
- fifo_data  out  DATA_W  write data to all FIFOs.
- err  out  1  one-cycle pulse: parity mismatch or invalid destination.
- pkt_done  out  1  one-cycle pulse: packet fully written to its FIFO.

## Operation
- Packet format:
  - Header byte: dest = [1:0], len = [7:2] (0..63).
  - Then `len` payload bytes, then 1 parity byte.
  - Parity byte = XOR of header and all payload bytes.
- accept = `pkt_valid && !busy && reset`.
- Gaps (`pkt_valid=0`) are legal anywhere; state and counters hold.
- FSM states: IDLE, LOAD, PARITY, DROP.
- IDLE:
  - `busy = pkt_valid && data_in[1:0]!=3 && fifo_full[data_in[1:0]]`.
  - On accept with dest 0..2: latch dest and len, set parity_acc=header, write header.
    - len=0 → PARITY; otherwise → LOAD.
  - On accept with dest 3: no write, latch len, err pulse → DROP.
- LOAD:
  - `busy = fifo_full[dest]`.
  - Each accept writes the byte, XORs it into parity_acc and decrements the count.
  - When the last payload byte is accepted → PARITY.
- PARITY:
  - `busy = fifo_full[dest]`.
  - On accept, write the parity byte → IDLE.
  - Next cycle: pkt_done=1, and err=1 if the byte ≠ parity_acc.
- DROP:
  - busy=0.
  - Silently consume len+1 bytes, with no writes and no pkt_done → IDLE.
- Writes:
  - `fifo_wr_en[dest] = accept` in a writing state, all other bits 0.
  - `fifo_data = data_in` (Mealy, same cycle).
  - Never more than one bit of `fifo_wr_en` set.
- Bytes with a bad parity are still written; `err` is advisory only.
- Byte counter is LEN_W bits and loaded with len.
  - No wrap: the transition fires when count reaches 1 on accept.
- Reset low on an edge:
  - state=IDLE, counter/parity_acc/dest=0, err=0, pkt_done=0.
  - A partial packet already in a FIFO stays there.
- While reset=0: `fifo_wr_en=000` and `busy=1` (combinational gating).

## Timing
- Reset values: state IDLE, err 0, pkt_done 0, fifo_wr_en 000.
- `fifo_data` follows `data_in`.
- `busy` and `fifo_wr_en` are combinational from state, `fifo_full`, `pkt_valid` and `data_in`.
  - A write lands on the same edge the byte is accepted.
  - A FIFO that reports full is therefore never written.
- `err` and `pkt_done` are registered and asserted exactly one cycle after the accepting edge.
- Throughput: 1 byte/cycle with no full stalls.
  - Back-to-back packets need no idle cycle: a header may be accepted on the edge after parity.
- `fifo_full` rising mid-packet stalls from that cycle.
- `fifo_full` falling allows acceptance on the same edge.

## Test plan
- Normal packet:
  - Stimulus: 0x0D (len 3, dest 1), 0x11, 0x22, 0x33, parity 0x0D, back to back.
  - Response: `fifo_wr_en=010` for 5 cycles with `fifo_data` matching input, pkt_done pulse, err=0.
- Bad parity:
  - Stimulus: same packet with parity 0xFF.
  - Response: all 5 bytes written, err and pkt_done pulse together one cycle after the parity byte.
- Full stall at header:
  - Stimulus: `fifo_full=001`, header 0x04 (len 1, dest 0) held valid; full cleared after 3 cycles.
  - Response: busy=1 and no writes for 3 cycles; header written on the first edge with full=0.
  - Then 0xAA and 0xAE complete the packet, err=0.
- Full mid-payload:
  - Stimulus: dest 2, len 4; `fifo_full[2]=1` for 2 cycles after payload byte 2, plus a 1-cycle `pkt_valid` gap.
  - Response: exactly 6 writes, byte order preserved, no write while full.
- Invalid dest:
  - Stimulus: header 0x0B (len 2, dest 3) plus 3 bytes, then a valid len-0 packet 0x02, 0x02.
  - Response: err pulse after the header, no writes for the first 4 bytes, then 2 writes with `fifo_wr_en=100` and a pkt_done pulse.
- Reset mid-packet:
  - Stimulus: reset=0 for 1 cycle during LOAD.
  - Response: `fifo_wr_en=000` and busy=1 during reset; the next header after reset is treated as a new packet.
